// File: rtl/mem_arbiter.sv
// Three-requester arbiter in front of the byte-serial memory port.
// Fixed priority LS > IF > PF, with fetch anti-starvation and flush discard.
module mem_arbiter #(
  parameter int unsigned STARVE_LIM = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ok,
  output logic [31:0] if_data,
  input  logic        ls_req,
  input  logic [31:0] ls_addr,
  input  logic        ls_wr,
  input  logic [1:0]  ls_len,
  input  logic [31:0] ls_wdata,
  output logic        ls_ok,
  output logic [31:0] ls_rdata,
  input  logic        pf_req,
  input  logic [31:0] pf_addr,
  output logic        pf_ok,
  output logic [31:0] pf_data,
  output logic        d_req,
  output logic [31:0] d_addr,
  output logic        d_wr,
  output logic [1:0]  d_len,
  output logic [31:0] d_wdata,
  input  logic        d_ack,
  input  logic [31:0] d_rdata
);

  typedef enum logic {S_IDLE, S_BUSY} state_e;
  typedef enum logic [1:0] {
    OWN_NONE, OWN_IF, OWN_LS, OWN_PF
  } own_e;

  localparam logic [3:0] LIM = 4'(STARVE_LIM);

  state_e      state_q, state_d;
  own_e        own_q, own_d;
  logic        killed_q, killed_d;
  logic [3:0]  streak_q, streak_d;
  logic        d_req_q, d_req_d;
  logic [31:0] d_addr_q, d_addr_d;
  logic        d_wr_q, d_wr_d;
  logic [1:0]  d_len_q, d_len_d;
  logic [31:0] d_wdata_q, d_wdata_d;
  logic        if_ok_q, if_ok_d;
  logic        ls_ok_q, ls_ok_d;
  logic        pf_ok_q, pf_ok_d;
  logic [31:0] if_data_q, if_data_d;
  logic [31:0] ls_rdata_q, ls_rdata_d;
  logic [31:0] pf_data_q, pf_data_d;

  logic idle, ls_c, if_c, pf_c;
  logic gnt_ls, gnt_if, gnt_pf;
  logic own_fetch, kill;

  function automatic logic [31:0] len_mask(input logic [1:0] len);
    logic [31:0] m;
    unique case (len)
      2'd0:    m = 32'h0000_00FF;
      2'd1:    m = 32'h0000_FFFF;
      2'd2:    m = 32'h00FF_FFFF;
      default: m = 32'hFFFF_FFFF;
    endcase
    return m;
  endfunction

  // A requester seeing its ok this cycle still holds req; mask it.
  assign idle   = (state_q == S_IDLE);
  assign ls_c   = ls_req & ~ls_ok_q;
  assign if_c   = if_req & ~flush & ~if_ok_q;
  assign pf_c   = pf_req & ~flush & ~if_req & ~ls_req & ~pf_ok_q;
  assign gnt_if = idle & if_c & ((streak_q == LIM) | ~ls_c);
  assign gnt_ls = idle & ls_c & ~gnt_if;
  assign gnt_pf = idle & pf_c & ~ls_c & ~if_c;

  assign own_fetch = (own_q == OWN_IF) | (own_q == OWN_PF);
  assign kill      = killed_q | (flush & own_fetch);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      own_q      <= OWN_NONE;
      killed_q   <= 1'b0;
      streak_q   <= '0;
      d_req_q    <= 1'b0;
      d_addr_q   <= '0;
      d_wr_q     <= 1'b0;
      d_len_q    <= '0;
      d_wdata_q  <= '0;
      if_ok_q    <= 1'b0;
      ls_ok_q    <= 1'b0;
      pf_ok_q    <= 1'b0;
      if_data_q  <= '0;
      ls_rdata_q <= '0;
      pf_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      own_q      <= own_d;
      killed_q   <= killed_d;
      streak_q   <= streak_d;
      d_req_q    <= d_req_d;
      d_addr_q   <= d_addr_d;
      d_wr_q     <= d_wr_d;
      d_len_q    <= d_len_d;
      d_wdata_q  <= d_wdata_d;
      if_ok_q    <= if_ok_d;
      ls_ok_q    <= ls_ok_d;
      pf_ok_q    <= pf_ok_d;
      if_data_q  <= if_data_d;
      ls_rdata_q <= ls_rdata_d;
      pf_data_q  <= pf_data_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    own_d      = own_q;
    killed_d   = killed_q;
    streak_d   = streak_q;
    d_req_d    = d_req_q;
    d_addr_d   = d_addr_q;
    d_wr_d     = d_wr_q;
    d_len_d    = d_len_q;
    d_wdata_d  = d_wdata_q;
    if_ok_d    = 1'b0;
    ls_ok_d    = 1'b0;
    pf_ok_d    = 1'b0;
    if_data_d  = if_data_q;
    ls_rdata_d = ls_rdata_q;
    pf_data_d  = pf_data_q;

    unique case (state_q)
      S_IDLE: begin
        if (gnt_ls | gnt_if | gnt_pf) begin
          state_d  = S_BUSY;
          d_req_d  = 1'b1;
          killed_d = 1'b0;
        end
        unique case (1'b1)
          gnt_ls: begin
            own_d     = OWN_LS;
            d_addr_d  = ls_addr;
            d_wr_d    = ls_wr;
            d_len_d   = ls_len;
            d_wdata_d = ls_wdata;
            if (!if_req)
              streak_d = '0;
            else if (streak_q != LIM)
              streak_d = streak_q + 4'd1;
          end
          gnt_if: begin
            own_d     = OWN_IF;
            d_addr_d  = if_addr;
            d_wr_d    = 1'b0;
            d_len_d   = 2'd3;
            d_wdata_d = '0;
            streak_d  = '0;
          end
          gnt_pf: begin
            own_d     = OWN_PF;
            d_addr_d  = pf_addr;
            d_wr_d    = 1'b0;
            d_len_d   = 2'd3;
            d_wdata_d = '0;
          end
          default: ;
        endcase
      end
      S_BUSY: begin
        if (flush && own_fetch)
          killed_d = 1'b1;
        if (d_ack) begin
          state_d  = S_IDLE;
          d_req_d  = 1'b0;
          killed_d = 1'b0;
          own_d    = OWN_NONE;
          if (!kill) begin
            unique case (own_q)
              OWN_IF: begin
                if_ok_d   = 1'b1;
                if_data_d = d_rdata;
              end
              OWN_LS: begin
                ls_ok_d    = 1'b1;
                ls_rdata_d = d_wr_q ? '0
                           : (d_rdata & len_mask(d_len_q));
              end
              OWN_PF: begin
                pf_ok_d   = 1'b1;
                pf_data_d = d_rdata;
              end
              default: ;
            endcase
          end
        end
      end
      default: ;
    endcase
  end

  assign d_req    = d_req_q;
  assign d_addr   = d_addr_q;
  assign d_wr     = d_wr_q;
  assign d_len    = d_len_q;
  assign d_wdata  = d_wdata_q;
  assign if_ok    = if_ok_q;
  assign ls_ok    = ls_ok_q;
  assign pf_ok    = pf_ok_q;
  assign if_data  = if_data_q;
  assign ls_rdata = ls_rdata_q;
  assign pf_data  = pf_data_q;

endmodule
